// File: rtl/exp2_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// exp2_pipe : two-stage valid/ready pipeline producing +/-2^x in signed Q(W-Q).Q
//             Optional saturation on overflow enabled by macro EXP2_SAT_EN.
// Revision  : 1.0 - initial release
// ============================================================================
module exp2_pipe #(
    parameter int W = 64,
    parameter int Q = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] exponent,
    input  logic         result_sign,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         ovf
);

    // Right shifts of Q+1 or more leave nothing of the (Q+1)-bit mantissa.
    localparam logic [W-1:0] C_ZERO_LIM = W'(Q + 1);

    logic                en;

    logic signed [W-1:0] i1_d;
    logic        [Q:0]   mant1_d;
    logic signed [W-1:0] i1_q;
    logic        [Q:0]   mant1_q;
    logic                sign1_q;
    logic                v1_q;

    logic        [W-1:0] mant_ext;
    logic        [W-1:0] neg_amt;
    logic        [W-1:0] mag_d;
    logic        [W-1:0] result_d;
    logic        [W-1:0] result_q;
    logic                out_valid_q;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Integer part by floor; fraction becomes the linear mantissa 1.f in [1,2).
    assign i1_d    = $signed(exponent) >>> Q;
    assign mant1_d = {1'b1, exponent[Q-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            i1_q    <= '0;
            mant1_q <= '0;
            sign1_q <= 1'b0;
        end else if (en) begin
            v1_q    <= in_valid;
            i1_q    <= i1_d;
            mant1_q <= mant1_d;
            sign1_q <= result_sign;
        end
    end

    assign mant_ext = {{(W-Q-1){1'b0}}, mant1_q};
    assign neg_amt  = -i1_q;

`ifdef EXP2_SAT_EN
    localparam logic [W-1:0] C_OVF_LIM = W'(W - Q - 1);
    logic ovf_d;
    logic ovf_q;

    always_comb begin
        mag_d = '0;
        ovf_d = 1'b0;
        if (!i1_q[W-1]) begin
            if ($unsigned(i1_q) >= C_OVF_LIM) begin
                mag_d = {1'b0, {(W-1){1'b1}}};
                ovf_d = 1'b1;
            end else begin
                mag_d = mant_ext << i1_q;
            end
        end else if (neg_amt < C_ZERO_LIM) begin
            mag_d = mant_ext >> neg_amt;
        end
    end
`else
    // Wrapping mode: shift amounts of W or more naturally yield zero.
    always_comb begin
        mag_d = '0;
        if (!i1_q[W-1]) begin
            mag_d = mant_ext << i1_q;
        end else if (neg_amt < C_ZERO_LIM) begin
            mag_d = mant_ext >> neg_amt;
        end
    end
`endif

    assign result_d = sign1_q ? -mag_d : mag_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (en) begin
            out_valid_q <= v1_q;
            result_q    <= result_d;
        end
    end

`ifdef EXP2_SAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_exp2_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_exp2_pipe : randomized scoreboard bench for exp2_pipe against an
//                arithmetic reference model (honours EXP2_SAT_EN).
// Revision     : 1.0 - initial release
// ============================================================================
module tb_exp2_pipe;

    localparam int W = 64;
    localparam int Q = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] exponent = '0;
    logic         result_sign = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_ex;
    int           n_chk = 0;
    int           n_fail = 0;
    int           n_out = 0;
    int           bp_mode = 0;
    int           out_before;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_res;
    logic         prev_ovf;

    exp2_pipe #(.W(W), .Q(Q)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exponent   (exponent),
        .result_sign(result_sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic o);
        exp_t e;
        e.res = r;
        e.ovf = o;
        return e;
    endfunction

    // 2^x ~ 2^floor(x) * (1 + frac(x)), scaled by 2^16, in plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] e, input logic s);
        longint       es, frac, ip;
        logic [127:0] p;
        logic [W-1:0] mag;
        exp_t         r;
        es    = longint'($signed(e));
        frac  = longint'({48'd0, e[15:0]});
        ip    = (es - frac) / 65536;
        mag   = '0;
        r.ovf = 1'b0;
        if (ip >= 47) begin
`ifdef EXP2_SAT_EN
            mag   = 64'h7FFF_FFFF_FFFF_FFFF;
            r.ovf = 1'b1;
`else
            if (ip < 64) begin
                p   = 128'(frac + 65536) * (128'd1 << ip);
                mag = p[63:0];
            end
`endif
        end else if (ip >= 0) begin
            mag = 64'(frac + 65536) * (64'd1 << ip);
        end else if (ip > -17) begin
            mag = 64'(frac + 65536) / (64'd1 << (-ip));
        end
        r.res = s ? (64'd0 - mag) : mag;
        return r;
    endfunction

    function automatic logic [W-1:0] gen();
        longint ip;
        if ($urandom_range(0, 3) == 0) return {$urandom, $urandom};
        ip = longint'($urandom_range(0, 72)) - 22;
        return 64'(ip * 65536 + longint'($urandom_range(0, 65535)));
    endfunction

    // Holds the pair until accepted; expected value is queued at acceptance.
    task automatic send(input logic [W-1:0] e, input logic s, input bit use_exp, input exp_t ex);
        int t = 0;
        in_valid    = 1'b1;
        exponent    = e;
        result_sign = s;
        forever begin
            @(negedge clk);
            if (in_ready && rst_n) break;
            t++;
            if (t > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: got in_ready %b expected 1", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        sb.push_back(use_exp ? ex : model(e, s));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_timeout", W'(t >= 300), '0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else if (bp_mode == 0) out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready", in_ready, W'(!out_valid || out_ready));
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_result", result, prev_res);
                check("stall_ovf", ovf, prev_ovf);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected no output", result);
                end else begin
                    mon_ex = sb.pop_front();
                    check("result", result, mon_ex.res);
                    check("ovf", ovf, mon_ex.ovf);
                    n_out++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            prev_ovf   = ovf;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        send(64'h0, 1'b0, 1'b1, mk(64'h0000_0000_0001_0000, 1'b0));
        in_valid = 1'b0;
        check("lat1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat2_valid", out_valid, 1);
        check("lat2_result", result, 64'h0000_0000_0001_0000);
        drain();

        send(64'hFFFF_FFFF_FFF8_0000, 1'b0, 1'b1, mk(64'h100, 1'b0));
        send(64'hFFFF_FFFF_FFF0_0000, 1'b0, 1'b1, mk(64'h1, 1'b0));
        send(64'hFFFF_FFFF_FFEF_0000, 1'b0, 1'b1, mk(64'h0, 1'b0));
        send(64'hFFFF_FFFF_FFEF_0000, 1'b1, 1'b1, mk(64'h0, 1'b0));
        send(64'h0000_0000_0000_8000, 1'b1, 1'b1, mk(64'hFFFF_FFFF_FFFE_8000, 1'b0));
        send(64'h0000_0000_002E_0000, 1'b0, 1'b1, mk(64'h4000_0000_0000_0000, 1'b0));
`ifdef EXP2_SAT_EN
        send(64'h0000_0000_002F_0000, 1'b0, 1'b1, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1));
        send(64'h0000_0000_002F_0000, 1'b1, 1'b1, mk(64'h8000_0000_0000_0001, 1'b1));
        send(64'h0000_0000_0040_0000, 1'b0, 1'b1, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1));
`else
        send(64'h0000_0000_002F_0000, 1'b0, 1'b1, mk(64'h8000_0000_0000_0000, 1'b0));
        send(64'h0000_0000_002F_0000, 1'b1, 1'b1, mk(64'h8000_0000_0000_0000, 1'b0));
        send(64'h0000_0000_0040_0000, 1'b0, 1'b1, mk(64'h0, 1'b0));
`endif
        in_valid = 1'b0;
        drain();

        bp_mode    = 2;
        out_ready  = 1'b1;
        out_before = n_out;
        fork
            begin
                for (int k = 0; k < 5; k++) send(gen(), 1'($urandom_range(0, 1)), 1'b0, mk('0, 1'b0));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    #1;
                    check("stall_in_ready_low", in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", W'(n_out - out_before), 5);

        out_ready = 1'b0;
        send(gen(), 1'b0, 1'b0, mk('0, 1'b0));
        send(gen(), 1'b1, 1'b0, mk('0, 1'b0));
        in_valid = 1'b0;
        check("inflight_valid", out_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_flush_valid", out_valid, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("rst_no_emit", out_valid, 0);
        end
        check("rst_sb_empty", W'(sb.size()), 0);

        bp_mode = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send(gen(), 1'($urandom_range(0, 1)), 1'b0, mk('0, 1'b0));
        end
        in_valid = 1'b0;
        bp_mode  = 0;
        @(posedge clk);
        #1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
